// File: rtl/ctrl_seq_if.sv
// Fetch-to-control instruction handshake: the fetch unit masters InstrValid/Instruction,
// ctrl_seq answers with InstrReady.
interface ctrl_seq_if #(
  parameter int IW = 9
);
  logic          InstrValid;
  logic [IW-1:0] Instruction;
  logic          InstrReady;

  modport master (output InstrValid, output Instruction, input InstrReady);
  modport slave  (input InstrValid, input Instruction, output InstrReady);
endinterface

// File: rtl/ctrl_seq.sv
// Sequenced control unit for the 9-bit ISA: instruction register, IDLE/EXEC/MEM_WAIT/HALT
// sequencer, control decode, sticky halt acknowledge and a saturating retired-instruction count.
module ctrl_seq #(
  parameter int IW      = 9,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  ctrl_seq_if.slave       fetch,
  input  logic [1:0]      SubstringIndex,
  output logic            JumpEqual,
  output logic            JumpNotEqual,
  output logic            OffsetEn,
  output logic [1:0]      PCRegSelect,
  output logic            RegWrEn,
  output logic            MemWrEn,
  output logic            MemRdEn,
  output logic [2:0]      WriteSource,
  output logic [3:0]      ReadRegAddrA,
  output logic [3:0]      ReadRegAddrB,
  output logic [3:0]      WriteRegAddr,
  output logic [3:0]      ALUOp,
  output logic [DW-1:0]   ImmOut,
  output logic            PCAdvance,
  output logic            Ack,
  output logic [CNTW-1:0] RetiredCount
);

  localparam logic [3:0] K_ADD = 4'd0;
  localparam logic [3:0] K_SUB = 4'd1;
  localparam logic [3:0] K_LSH = 4'd2;
  localparam logic [3:0] K_RSH = 4'd3;
  localparam logic [3:0] K_XOR = 4'd4;
  localparam logic [3:0] K_RXR = 4'd5;
  localparam logic [3:0] K_ORR = 4'd6;
  localparam logic [3:0] K_SB1 = 4'd7;
  localparam logic [3:0] K_DB1 = 4'd11;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_HALT} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ir;
  logic [3:0]      r_wait;
  logic            r_ack;
  logic [CNTW-1:0] r_retired;

  logic       w_exec, w_wait, w_is_ld, w_retire, w_ready, w_accept, w_halt_instr;
  logic [5:0] w_op;
  logic [3:0] w_rd, w_rc, w_rs;

  assign w_op         = r_ir[IW-1 -: 6];
  assign w_rd         = {1'b0, r_ir[4:2]};
  assign w_rc         = 4'd9 + {2'b00, r_ir[2:1]};
  assign w_rs         = 4'd13 + {2'b00, r_ir[2:1]};
  assign w_exec       = (r_state == S_EXEC);
  assign w_wait       = (r_state == S_MEM_WAIT);
  assign w_is_ld      = (r_ir[IW-1 -: 5] == 5'b01000);
  // Loads retire on their writeback cycle; everything else retires in EXEC.
  assign w_retire     = (w_exec & ~w_is_ld) | (w_wait & (r_wait == 4'd0));
  assign w_ready      = Reset & ((r_state == S_IDLE) | w_retire);
  assign w_accept     = fetch.InstrValid & w_ready;
  assign w_halt_instr = &fetch.Instruction;

  assign fetch.InstrReady = w_ready;
  assign PCAdvance        = w_retire;
  assign Ack              = r_ack;
  assign RetiredCount     = r_retired;

  // Sequencer: IR capture, state transitions, load wait counter, halt flag, retire count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_wait    <= 4'd0;
      r_ack     <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_accept) begin
        r_ir    <= fetch.Instruction;
        r_state <= w_halt_instr ? S_HALT : S_EXEC;
        r_ack   <= w_halt_instr;
      end else if (w_retire) begin
        r_state <= S_IDLE;
      end else if (w_exec) begin
        r_state <= S_MEM_WAIT;
        r_wait  <= LAT_M1;
      end else if (w_wait) begin
        r_wait  <= r_wait - 4'd1;
      end else begin
        r_state <= r_state;
      end
      if (w_retire && (r_retired != {CNTW{1'b1}})) begin
        r_retired <= r_retired + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Control decode from IR; only EXEC/MEM_WAIT drive anything, so IDLE, HALT and reset read as NOP.
  always_comb begin
    JumpEqual    = 1'b0;
    JumpNotEqual = 1'b0;
    OffsetEn     = 1'b0;
    PCRegSelect  = 2'd0;
    RegWrEn      = 1'b0;
    MemWrEn      = 1'b0;
    MemRdEn      = 1'b0;
    WriteSource  = 3'd0;
    ReadRegAddrA = 4'd0;
    ReadRegAddrB = 4'd0;
    WriteRegAddr = 4'd0;
    ALUOp        = K_ADD;
    ImmOut       = '0;
    casez ({w_exec | w_wait, w_op})
      7'b1_000???: begin WriteRegAddr = {1'b0, r_ir[5:3]}; ReadRegAddrA = 4'd8;
                         ReadRegAddrB = {1'b0, r_ir[2:0]}; ALUOp = K_LSH; RegWrEn = w_exec; end
      7'b1_001???: begin WriteRegAddr = {1'b0, r_ir[5:3]}; ReadRegAddrA = 4'd8;
                         ReadRegAddrB = {1'b0, r_ir[2:0]}; ALUOp = K_RSH; RegWrEn = w_exec; end
      7'b1_0110??: begin ReadRegAddrA = w_rd; ReadRegAddrB = 4'd8; WriteRegAddr = w_rd;
                         ALUOp = K_XOR; RegWrEn = w_exec; end
      7'b1_0111??: begin ReadRegAddrA = w_rd; WriteRegAddr = w_rd; ALUOp = K_RXR; RegWrEn = w_exec; end
      7'b1_1101??: begin ReadRegAddrA = w_rd; ReadRegAddrB = {2'b01, r_ir[1:0]}; WriteRegAddr = w_rd;
                         ALUOp = K_ORR; RegWrEn = w_exec; end
      7'b1_1110??: begin ReadRegAddrA = w_rd; ReadRegAddrB = 4'd8; WriteRegAddr = w_rd;
                         ALUOp = r_ir[1] ? K_SUB : K_ADD; RegWrEn = w_exec; end
      7'b1_1111??: begin WriteRegAddr = 4'd8; WriteSource = 3'b100; ImmOut = DW'(r_ir[4:0]);
                         RegWrEn = w_exec; end
      7'b1_1000??: begin PCRegSelect = r_ir[3:2]; JumpEqual = ~r_ir[4]; JumpNotEqual = r_ir[4]; end
      7'b1_1001??: begin PCRegSelect = r_ir[4:3]; OffsetEn = r_ir[2]; end
      7'b1_1010??: begin WriteRegAddr = w_rd; ReadRegAddrA = 4'd6;
                         WriteSource = r_ir[1] ? 3'b011 : 3'b010; RegWrEn = w_exec; end
      // Load keeps its addresses/source across the wait; the write strobe fires once on writeback.
      7'b1_01000?: begin ReadRegAddrA = 4'd1; WriteRegAddr = {1'b0, r_ir[3:1]}; WriteSource = 3'b001;
                         MemRdEn = w_exec; RegWrEn = w_wait & (r_wait == 4'd0); end
      7'b1_01001?: begin MemWrEn = w_exec; ReadRegAddrA = 4'd1; ReadRegAddrB = {1'b0, r_ir[3:1]}; end
      7'b1_101100: begin WriteRegAddr = w_rc; RegWrEn = w_exec; end
      7'b1_101101: begin WriteRegAddr = w_rc; ReadRegAddrA = 4'd8; ReadRegAddrB = w_rc; RegWrEn = w_exec; end
      7'b1_101110: begin MemWrEn = w_exec; ReadRegAddrA = w_rs; ReadRegAddrB = w_rc; end
      7'b1_101111: begin ReadRegAddrA = 4'd12; end
      7'b1_1100??: begin ReadRegAddrA = 4'd8; ReadRegAddrB = 4'd0; end
      7'b1_01010?: begin ReadRegAddrA = 4'd5; WriteRegAddr = {1'b0, r_ir[3:1]};
                         ALUOp = K_SB1 + {2'b00, SubstringIndex}; RegWrEn = w_exec; end
      7'b1_01011?: begin ReadRegAddrA = 4'd5; ReadRegAddrB = 4'd6; WriteRegAddr = {1'b0, r_ir[3:1]};
                         ALUOp = K_DB1 + {2'b00, SubstringIndex}; RegWrEn = w_exec; end
      default: begin ALUOp = K_ADD; end
    endcase
  end

endmodule
